pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage of the RISC core.
//  Holds the PC; applies sequential increment, stall, PC-relative branch, absolute jump,
//  call/return through a small return-address stack (RAS), and trap redirect.
//  Outputs the current fetch address and a registered misalignment flag to the fetch/decode stages.
// PARAMETERS
//  XLEN       32            PC / address width in bits
//  STEP       4             sequential increment in bytes; power of two >= 1
//  RESET_VEC  32'h0000_0000 PC value after reset
//  TRAP_VEC   32'h0000_0010 PC value loaded on trap
//  RAS_DEPTH  4             return-address stack entries; power of two >= 2
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     asynchronous active-low reset
//  stall         in   1     hold PC and RAS this cycle
//  trap          in   1     redirect to TRAP_VEC; overrides everything including stall
//  jump          in   1     absolute redirect to jump_addr
//  call          in   1     qualifier for jump: also push return address (pc+STEP); ignored without jump
//  jump_addr     in   XLEN  absolute target
//  ret           in   1     redirect to RAS top and pop
//  branch        in   1     PC-relative redirect
//  branch_off    in   XLEN  signed two's-complement byte offset added to pc
//  pc            out  XLEN  current fetch address (registered)
//  pc_next       out  XLEN  combinational value pc will take at next edge
//  ras_empty     out  1     RAS holds 0 entries
//  ras_full      out  1     RAS holds RAS_DEPTH entries
//  ras_underflow out  1     registered 1-cycle pulse: ret issued while RAS empty
//  misalign      out  1     registered: pc[log2(STEP)-1:0] != 0 (tied 0 when STEP==1)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_VEC; RAS count=0, entries=0; ras_empty=1, ras_full=0,
//    ras_underflow=0, misalign=RESET_VEC alignment.
//  Per rising edge, first match wins:
//    1 trap            : pc<=TRAP_VEC; RAS unchanged
//    2 stall           : pc, RAS held; all other requests dropped (requester re-asserts)
//    3 jump (+call)    : pc<=jump_addr; if call, push pc+STEP
//    4 ret             : RAS non-empty -> pc<=top, pop;
//                        RAS empty -> pc<=pc+STEP, ras_underflow=1 for one cycle
//    5 branch          : pc<=pc+branch_off
//    6 default         : pc<=pc+STEP
//  All pc arithmetic is modulo 2^XLEN (wraps silently, no flag).
//  Simultaneous jump+ret: jump wins, ret dropped, no pop.
//  call+jump with RAS full: push overwrites oldest entry (circular); count stays RAS_DEPTH.
//  RAS is a circular buffer with top pointer + count; push and pop never occur in the same cycle.
//  Latency: redirect visible on pc one cycle after the request edge; pc_next reflects it
//    combinationally in the same cycle.
//  misalign: registered from the new pc each edge; it does not block the update.
// TESTING
//  T1 reset: rst_n=0 mid-run, async, with clk stopped -> pc=0, ras_empty=1 immediately;
//     release, 3 idle clocks -> pc=0x0,0x4,0x8,0xC.
//  T2 stall/trap: at pc=0x20 assert stall+jump(0x100) -> pc stays 0x20;
//     stall+trap -> pc=0x10 next cycle.
//  T3 branch: pc=0x40, branch_off=0xFFFF_FFF0 -> 0x30; pc=0xFFFF_FFFC idle -> 0x0 (wrap).
//  T4 call/ret: call+jump(0x200) at pc=0x80 -> pc=0x200, RAS top=0x84;
//     ret -> pc=0x84, ras_empty=1.
//  T5 RAS overflow: 5 calls from pcs 0x0,0x100,0x200,0x300,0x400 with DEPTH=4 ->
//     rets yield 0x404,0x304,0x204,0x104; 5th ret -> ras_underflow pulse, pc+4.
//  T6 priority/misalign: jump+ret+branch together -> jump target, RAS untouched;
//     jump_addr=0x102 -> misalign=1 next cycle, then 0x106.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-stage PC control bundle: redirect requests in, fetch address and RAS status out.
// The pc_unit is the slave; the requesting pipeline logic is the master.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            trap;
  logic            jump;
  logic            call;
  logic [XLEN-1:0] jump_addr;
  logic            ret;
  logic            branch;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;
  logic            misalign;

  modport master (
    output stall, trap, jump, call, jump_addr, ret, branch, branch_off,
    input  pc, pc_next, ras_empty, ras_full, ras_underflow, misalign
  );

  modport slave (
    input  stall, trap, jump, call, jump_addr, ret, branch, branch_off,
    output pc, pc_next, ras_empty, ras_full, ras_underflow, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with trap/stall/jump/call/ret/branch redirect and a circular return-address stack.
// Redirects land on pc one edge after the request; pc_next shows them combinationally. Stall holds all state.
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter int              STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0010),
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);
  localparam int              PW         = $clog2(RAS_DEPTH);
  localparam int              CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] nxt_pc;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [PW-1:0]   top_inc;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  logic            underflow;
  logic            underflow_q;
  logic            misalign_q;

  assign seq_pc  = pc_q + STEP_V;
  assign top_inc = top + 1'b1;

  // First match wins; a ret on an empty stack falls through to the sequential pc.
  always_comb begin
    nxt_pc    = seq_pc;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    if (bus.trap) begin
      nxt_pc = TRAP_VEC;
    end else if (bus.stall) begin
      nxt_pc = pc_q;
    end else if (bus.jump) begin
      nxt_pc = bus.jump_addr;
      push   = bus.call;
    end else if (bus.ret) begin
      if (cnt != '0) begin
        nxt_pc = ras[top];
        pop    = 1'b1;
      end else begin
        underflow = 1'b1;
      end
    end else if (bus.branch) begin
      nxt_pc = pc_q + bus.branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VEC;
      top         <= '0;
      cnt         <= '0;
      underflow_q <= 1'b0;
      misalign_q  <= |(RESET_VEC & ALIGN_MASK);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else begin
      pc_q        <= nxt_pc;
      underflow_q <= underflow;
      misalign_q  <= |(nxt_pc & ALIGN_MASK);
      // When full, the push lands on the oldest slot and the count saturates.
      if (push) begin
        ras[top_inc] <= seq_pc;
        top          <= top_inc;
        if (cnt != FULL_CNT) begin
          cnt <= cnt + 1'b1;
        end
      end else if (pop) begin
        top <= top - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_next       = nxt_pc;
  assign bus.ras_empty     = (cnt == '0);
  assign bus.ras_full      = (cnt == FULL_CNT);
  assign bus.ras_underflow = underflow_q;
  assign bus.misalign      = misalign_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: each step queues its pc_next and post-edge expectations,
// a negedge monitor pops and compares them.
module tb_pc_unit;
  localparam logic [5:0] TRP = 6'b100000;
  localparam logic [5:0] STL = 6'b010000;
  localparam logic [5:0] JMP = 6'b001000;
  localparam logic [5:0] CAL = 6'b000100;
  localparam logic [5:0] RET = 6'b000010;
  localparam logic [5:0] BRN = 6'b000001;
  localparam logic [5:0] IDL = 6'b000000;
  // flag order {ras_empty, ras_full, ras_underflow, misalign}
  localparam logic [3:0] FE  = 4'b1000;
  localparam logic [3:0] FN  = 4'b0000;
  localparam logic [3:0] FF  = 4'b0100;
  localparam logic [3:0] FU  = 4'b1010;
  localparam logic [3:0] FM  = 4'b0001;

  typedef struct {
    int          due;
    bit          is_next;
    string       tag;
    logic [31:0] pc;
    logic [3:0]  fl;
  } exp_t;

  logic clk   = 1'b1;
  bit   clk_en = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    {bus.trap, bus.stall, bus.jump, bus.call, bus.ret, bus.branch} = IDL;
    bus.jump_addr  = '0;
    bus.branch_off = '0;
  endtask

  task automatic step(input string tag, input logic [5:0] ctl, input logic [31:0] val,
                      input logic [31:0] exp_pc, input logic [3:0] fl);
    exp_t e;
    {bus.trap, bus.stall, bus.jump, bus.call, bus.ret, bus.branch} = ctl;
    bus.jump_addr  = val;
    bus.branch_off = val;
    e.due = cyc;     e.is_next = 1'b1; e.tag = {tag, ".nxt"}; e.pc = exp_pc; e.fl = fl;
    sbq.push_back(e);
    e.due = cyc + 1; e.is_next = 1'b0; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.tag, e.due, cyc);
      end else if (e.is_next) begin
        chk(e.tag, bus.pc_next, e.pc);
      end else begin
        chk(e.tag,              bus.pc,                   e.pc);
        chk({e.tag, ".empty"},  32'(bus.ras_empty),       32'(e.fl[3]));
        chk({e.tag, ".full"},   32'(bus.ras_full),        32'(e.fl[2]));
        chk({e.tag, ".uflow"},  32'(bus.ras_underflow),   32'(e.fl[1]));
        chk({e.tag, ".misal"},  32'(bus.misalign),        32'(e.fl[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #2;
    chk("rst0.pc",    bus.pc,                  32'h0);
    chk("rst0.empty", 32'(bus.ras_empty),      32'h1);
    chk("rst0.full",  32'(bus.ras_full),       32'h0);
    chk("rst0.uflow", 32'(bus.ras_underflow),  32'h0);
    chk("rst0.misal", 32'(bus.misalign),       32'h0);
    rst_n = 1'b1;
    #2 clk_en = 1'b1;

    // call/ret
    step("t4.jmp",    JMP,       32'h80,        32'h80,        FE);
    step("t4.call",   CAL | JMP, 32'h200,       32'h200,       FN);
    step("t4.ret",    RET,       32'h0,         32'h84,        FE);
    // stall/trap
    step("t2.jmp",    JMP,       32'h20,        32'h20,        FE);
    step("t2.stall",  STL | JMP, 32'h100,       32'h20,        FE);
    step("t2.trap",   STL | TRP, 32'h0,         32'h10,        FE);
    // branch and wrap
    step("t3.jmp",    JMP,       32'h40,        32'h40,        FE);
    step("t3.br",     BRN,       32'hFFFF_FFF0, 32'h30,        FE);
    step("t3.jtop",   JMP,       32'hFFFF_FFFC, 32'hFFFF_FFFC, FE);
    step("t3.wrap",   IDL,       32'h0,         32'h0,         FE);
    // RAS overflow then drain to underflow
    step("t5.call1",  CAL | JMP, 32'h100,       32'h100,       FN);
    step("t5.call2",  CAL | JMP, 32'h200,       32'h200,       FN);
    step("t5.call3",  CAL | JMP, 32'h300,       32'h300,       FN);
    step("t5.call4",  CAL | JMP, 32'h400,       32'h400,       FF);
    step("t5.call5",  CAL | JMP, 32'h500,       32'h500,       FF);
    step("t5.ret1",   RET,       32'h0,         32'h404,       FN);
    step("t5.ret2",   RET,       32'h0,         32'h304,       FN);
    step("t5.ret3",   RET,       32'h0,         32'h204,       FN);
    step("t5.ret4",   RET,       32'h0,         32'h104,       FE);
    step("t5.ret5",   RET,       32'h0,         32'h108,       FU);
    step("t5.after",  IDL,       32'h0,         32'h10C,       FE);
    // priority and misalignment
    step("t6.call",   CAL | JMP, 32'h600,       32'h600,       FN);
    step("t6.prio",   JMP | RET | BRN, 32'h700, 32'h700,       FN);
    step("t6.mis",    JMP,       32'h102,       32'h102,       FM);
    step("t6.mis2",   IDL,       32'h0,         32'h106,       FM);
    step("t6.ret",    RET,       32'h0,         32'h110,       FE);
    step("t6.call2",  CAL | JMP, 32'h40,        32'h40,        FN);
    step("t6.stret",  STL | RET, 32'h0,         32'h40,        FN);
    step("t6.trret",  TRP | RET, 32'h0,         32'h10,        FN);

    // async reset with the clock parked high
    @(negedge clk);
    @(posedge clk);
    #1 clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    chk("t1.pc",      bus.pc,                  32'h0);
    chk("t1.empty",   32'(bus.ras_empty),      32'h1);
    chk("t1.full",    32'(bus.ras_full),       32'h0);
    chk("t1.misal",   32'(bus.misalign),       32'h0);
    #5 rst_n = 1'b1;
    #2;
    chk("t1.rel.pc",  bus.pc,                  32'h0);
    clk_en = 1'b1;
    step("t1.idle1",  IDL,       32'h0,         32'h4,         FE);
    step("t1.idle2",  IDL,       32'h0,         32'h8,         FE);
    step("t1.idle3",  IDL,       32'h0,         32'hC,         FE);

    repeat (3) @(negedge clk);
    #1;
    while (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: expectation never checked", sbq[0].tag);
      void'(sbq.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
